// File: rtl/fire_scheduler_pkg.sv
// Shared types for the fire scheduler: coordinate type and FSM state encoding.
package fire_scheduler_pkg;

  localparam int COORD_WIDTH = 11;

  typedef logic [COORD_WIDTH-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    LAUNCH   = 2'd2,
    COOLDOWN = 2'd3
  } fire_state_t;

endpackage

// File: rtl/fire_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping modulo N. Reusable for any shared resource.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = IDXW'(cand);
        grant       = '0;
        grant[cand] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/fire_scheduler.sv
// Fire scheduler: shares one missile pool between several shooters.
// Round-robin pick, single launch pulse with origin, frame-based cooldown,
// and no launch into a full pool.
module fire_scheduler
  import fire_scheduler_pkg::*;
#(
  parameter int REQUESTERS      = 4,
  parameter int SHOT_AMOUNT     = 7,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int PIXEL_WIDTH     = COORD_WIDTH,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   startOfFrame,
  input  logic                                   enable,
  input  logic [REQUESTERS-1:0]                  fire_req,
  input  logic [REQUESTERS-1:0][PIXEL_WIDTH-1:0] shooter_X,
  input  logic [REQUESTERS-1:0][PIXEL_WIDTH-1:0] shooter_Y,
  input  logic [SHOT_AMOUNT-1:0]                 missile_active,
  output logic                                   shooting_pulse,
  output logic [PIXEL_WIDTH-1:0]                 origin_X,
  output logic [PIXEL_WIDTH-1:0]                 origin_Y,
  output logic [REQUESTERS-1:0]                  grant,
  output logic                                   busy,
  output logic [CNT_WIDTH-1:0]                   shots_fired
);

  localparam int IDXW = $clog2(REQUESTERS);
  localparam logic [CNT_WIDTH-1:0] CD_INIT = CNT_WIDTH'(COOLDOWN_FRAMES);

  fire_state_t state_r, state_s;
  logic [REQUESTERS-1:0]  req_latch_r, req_latch_s;
  logic [IDXW-1:0]        rr_ptr_r, rr_ptr_s;
  logic [IDXW-1:0]        winner_r, winner_s;
  logic [REQUESTERS-1:0]  grant_r, grant_s;
  logic [PIXEL_WIDTH-1:0] origin_x_r, origin_x_s;
  logic [PIXEL_WIDTH-1:0] origin_y_r, origin_y_s;
  logic                   pulse_r, pulse_s;
  logic                   busy_r;
  logic [CNT_WIDTH-1:0]   shots_r, shots_s;
  logic [CNT_WIDTH-1:0]   cooldown_r, cooldown_s;

  logic                   pool_free_s;
  logic [REQUESTERS-1:0]  arb_req_s;
  logic [REQUESTERS-1:0]  arb_grant_s;
  logic [IDXW-1:0]        arb_idx_s;
  logic                   arb_any_s;

  assign pool_free_s = ~&missile_active;

  // Arbitrate on live requests in IDLE (they become the latch), else on the latch.
  always_comb begin
    if (state_r == IDLE) begin
      arb_req_s = fire_req;
    end else begin
      arb_req_s = req_latch_r;
    end
  end

  rr_arbiter #(
    .N    (REQUESTERS),
    .IDXW (IDXW)
  ) u_arb (
    .req   (arb_req_s),
    .ptr   (rr_ptr_r),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .any   (arb_any_s)
  );

  // Next-state and next-output logic; everything holds unless a state acts on it.
  always_comb begin
    state_s     = state_r;
    req_latch_s = req_latch_r;
    rr_ptr_s    = rr_ptr_r;
    winner_s    = winner_r;
    grant_s     = grant_r;
    origin_x_s  = origin_x_r;
    origin_y_s  = origin_y_r;
    pulse_s     = 1'b0;
    shots_s     = shots_r;
    cooldown_s  = cooldown_r;
    case (state_r)
      IDLE: begin
        if (enable && pool_free_s && arb_any_s) begin
          // Origin is captured here so it is stable a full cycle before the pulse.
          state_s     = ARB;
          req_latch_s = fire_req;
          grant_s     = arb_grant_s;
          origin_x_s  = shooter_X[arb_idx_s];
          origin_y_s  = shooter_Y[arb_idx_s];
        end else begin
          state_s = IDLE;
        end
      end
      ARB: begin
        if (pool_free_s) begin
          state_s  = LAUNCH;
          pulse_s  = 1'b1;
          winner_s = arb_idx_s;
        end else begin
          // Pool filled while arbitrating: abandon, pointer untouched.
          state_s = IDLE;
          grant_s = '0;
        end
      end
      LAUNCH: begin
        grant_s = '0;
        if (winner_r == IDXW'(REQUESTERS - 1)) begin
          rr_ptr_s = '0;
        end else begin
          rr_ptr_s = winner_r + IDXW'(1);
        end
        if (shots_r != '1) begin
          shots_s = shots_r + CNT_WIDTH'(1);
        end else begin
          shots_s = shots_r;
        end
        if (COOLDOWN_FRAMES == 0) begin
          state_s = IDLE;
        end else begin
          state_s    = COOLDOWN;
          cooldown_s = CD_INIT;
        end
      end
      COOLDOWN: begin
        if (cooldown_r == '0) begin
          state_s = IDLE;
        end else if (startOfFrame) begin
          cooldown_s = cooldown_r - CNT_WIDTH'(1);
          if (cooldown_r == CNT_WIDTH'(1)) begin
            state_s = IDLE;
          end else begin
            state_s = COOLDOWN;
          end
        end else begin
          state_s = COOLDOWN;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      req_latch_r <= '0;
      rr_ptr_r    <= '0;
      winner_r    <= '0;
      grant_r     <= '0;
      origin_x_r  <= '0;
      origin_y_r  <= '0;
      pulse_r     <= 1'b0;
      busy_r      <= 1'b0;
      shots_r     <= '0;
      cooldown_r  <= '0;
    end else begin
      state_r     <= state_s;
      req_latch_r <= req_latch_s;
      rr_ptr_r    <= rr_ptr_s;
      winner_r    <= winner_s;
      grant_r     <= grant_s;
      origin_x_r  <= origin_x_s;
      origin_y_r  <= origin_y_s;
      pulse_r     <= pulse_s;
      busy_r      <= (state_s != IDLE);
      shots_r     <= shots_s;
      cooldown_r  <= cooldown_s;
    end
  end

  assign shooting_pulse = pulse_r;
  assign origin_X       = origin_x_r;
  assign origin_Y       = origin_y_r;
  assign grant          = grant_r;
  assign busy           = busy_r;
  assign shots_fired    = shots_r;

endmodule
